// File: rtl/i2s_pkg.sv
// Shared I2S frame geometry: 64-slot stereo frame, two 32-slot words.
package i2s_pkg;

    localparam int unsigned FRAME_SLOTS = 64;
    localparam int unsigned WORD_SLOTS  = 32;

    typedef logic [5:0] slot_t;

    localparam slot_t LEFT_MSB_SLOT    = 6'd1;
    localparam slot_t RIGHT_MSB_SLOT   = 6'd33;
    localparam slot_t LEFT_LATCH_SLOT  = 6'd32;
    localparam slot_t RIGHT_LATCH_SLOT = 6'd0;

    // Place a w-bit sample (zero-extended in v) at the top of a 32-bit slot word.
    function automatic logic [WORD_SLOTS-1:0] msb_align(input logic [WORD_SLOTS-1:0] v,
                                                        input int unsigned w);
        return v << (WORD_SLOTS - w);
    endfunction

endpackage

// File: rtl/i2s_transceiver_if.sv
// I2S pins and parallel sample ports of the transceiver, grouped for reuse.
interface i2s_transceiver_if
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);

    logic             sck;
    logic             ws;
    slot_t            frame_posn;
    logic             sd_in;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             rx_valid;
    logic [WIDTH-1:0] tx_left;
    logic [WIDTH-1:0] tx_right;
    logic             sd_out;

    modport master (
        output sck, ws, frame_posn, left, right, rx_valid, sd_out,
        input  sd_in, tx_left, tx_right
    );

    modport slave (
        input  sck, ws, frame_posn, left, right, rx_valid, sd_out,
        output sd_in, tx_left, tx_right
    );

endinterface

// File: rtl/i2s_clock_gen.sv
// Bit clock, edge enables and frame slot counter derived from the system clock.
module i2s_clock_gen
    import i2s_pkg::*;
#(
    parameter int unsigned CK_DIV_LOG2 = 2
)
(
    input  logic  ck,
    input  logic  rst_n,
    output logic  sck,
    output logic  sck_rise,
    output logic  sck_fall,
    output slot_t frame_posn,
    output logic  ws
);

    localparam logic [CK_DIV_LOG2-1:0] PRESCALE_STEP = 1;

    logic [CK_DIV_LOG2-1:0] prescaler;
    logic [CK_DIV_LOG2-1:0] prescaler_next;

    assign prescaler_next = prescaler + PRESCALE_STEP;

    // Enables mark the ck edge on which sck itself changes, so sck stays a plain flop.
    assign sck_rise = ~sck &  prescaler_next[CK_DIV_LOG2-1];
    assign sck_fall =  sck & ~prescaler_next[CK_DIV_LOG2-1];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            sck        <= 1'b0;
            frame_posn <= '0;
        end else begin
            prescaler <= prescaler_next;
            sck       <= prescaler_next[CK_DIV_LOG2-1];
            if (sck_fall) begin
                frame_posn <= frame_posn + 6'd1;
            end
        end
    end

    assign ws = frame_posn[5];

endmodule

// File: rtl/i2s_transceiver.sv
// Single-clock I2S master: generates SCK/WS and runs the stereo receiver and transmitter.
module i2s_transceiver
    import i2s_pkg::*;
#(
    parameter int unsigned CK_DIV_LOG2 = 2,
    parameter int unsigned WIDTH       = 16
)
(
    input  logic             ck,
    input  logic             rst_n,
    i2s_transceiver_if.master bus
);

    logic  sck;
    logic  ws;
    logic  sck_rise;
    logic  sck_fall;
    slot_t frame_posn;
    slot_t posn_next;

    i2s_clock_gen #(
        .CK_DIV_LOG2(CK_DIV_LOG2)
    ) u_clock_gen (
        .ck        (ck),
        .rst_n     (rst_n),
        .sck       (sck),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .frame_posn(frame_posn),
        .ws        (ws)
    );

    assign posn_next = frame_posn + 6'd1;

    logic [WORD_SLOTS-1:0] rx_shreg;
    logic [WORD_SLOTS-1:0] rx_shreg_next;
    logic [WIDTH-1:0]      left_q;
    logic [WIDTH-1:0]      right_q;
    logic                  rx_valid_q;

    assign rx_shreg_next = {rx_shreg[WORD_SLOTS-2:0], bus.sd_in};

    // Latch checks use the shifted value so the slot's own bit lands in the word.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rx_shreg   <= '0;
            left_q     <= '0;
            right_q    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (sck_rise) begin
                rx_shreg <= rx_shreg_next;
                if (frame_posn == LEFT_LATCH_SLOT) begin
                    left_q <= rx_shreg_next[WORD_SLOTS-1 -: WIDTH];
                end
                if (frame_posn == RIGHT_LATCH_SLOT) begin
                    right_q    <= rx_shreg_next[WORD_SLOTS-1 -: WIDTH];
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

    logic [WORD_SLOTS-1:0] tx_shreg;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            tx_shreg <= '0;
        end else if (sck_fall) begin
            if (posn_next == LEFT_MSB_SLOT) begin
                tx_shreg <= msb_align(WORD_SLOTS'(bus.tx_left), WIDTH);
            end else if (posn_next == RIGHT_MSB_SLOT) begin
                tx_shreg <= msb_align(WORD_SLOTS'(bus.tx_right), WIDTH);
            end else begin
                tx_shreg <= {tx_shreg[WORD_SLOTS-2:0], 1'b0};
            end
        end
    end

    assign bus.sck        = sck;
    assign bus.ws         = ws;
    assign bus.frame_posn = frame_posn;
    assign bus.left       = left_q;
    assign bus.right      = right_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.sd_out     = tx_shreg[WORD_SLOTS-1];

endmodule

// File: tb/tb_i2s_transceiver.sv
// Randomized bench for i2s_transceiver against a slot-stream reference model.
module tb_i2s_transceiver;
    import i2s_pkg::*;

    localparam int unsigned CKD    = 2;
    localparam int unsigned W      = 16;
    localparam int unsigned P      = 1 << CKD;
    localparam int unsigned NWORDS = 24;
    localparam int unsigned NSLOTS = NWORDS * WORD_SLOTS;

    logic ck      = 1'b0;
    logic rst_n   = 1'b1;
    logic ext_sd  = 1'b0;
    logic loop_en = 1'b0;

    i2s_transceiver_if #(.WIDTH(W)) bus ();

    assign bus.sd_in = loop_en ? bus.sd_out : ext_sd;

    i2s_transceiver #(
        .CK_DIV_LOG2(CKD),
        .WIDTH      (W)
    ) dut (
        .ck   (ck),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 ck = ~ck;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned n     = 0;
    int unsigned phase = 0;

    // Stream model: words are sent back-to-back from slot 1 onward, 32 slots each.
    logic [31:0]  rx_words [NWORDS];
    logic [31:0]  tx_words [NWORDS];
    logic         rx_bits  [NSLOTS];
    logic [W-1:0] exp_left;
    logic [W-1:0] exp_right;
    logic         exp_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40) $display("FAIL %s t=%0t n=%0d: got %0h want %0h", tag, $time, n, got, want);
        end
    endtask

    function automatic logic ext_bit(input int unsigned a);
        int unsigned b;
        if (a == 0) return 1'b0;
        b = a - 1;
        return rx_words[b / WORD_SLOTS][WORD_SLOTS - 1 - (b % WORD_SLOTS)];
    endfunction

    function automatic logic tx_bit(input int unsigned a);
        int unsigned pos;
        if (a == 0) return 1'b0;
        pos = (a - 1) % WORD_SLOTS;
        if (pos >= W) return 1'b0;
        return tx_words[(a - 1) / WORD_SLOTS][W - 1 - pos];
    endfunction

    // Word seen on sd_in over the 32 slots ending at slot a; slots before reset read as 0.
    function automatic logic [W-1:0] captured(input int unsigned a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (int'(a) - i >= 0) v[i] = rx_bits[int'(a) - i];
        end
        return v[31 -: W];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_sck"},   32'(bus.sck), 32'd0);
        check({tag, "_ws"},    32'(bus.ws), 32'd0);
        check({tag, "_posn"},  32'(bus.frame_posn), 32'd0);
        check({tag, "_left"},  32'(bus.left), 32'd0);
        check({tag, "_right"}, 32'(bus.right), 32'd0);
        check({tag, "_valid"}, 32'(bus.rx_valid), 32'd0);
        check({tag, "_sdout"}, 32'(bus.sd_out), 32'd0);
    endtask

    // Set inputs for the coming ck edge n+1 and log what the receiver will see.
    task automatic drive();
        int unsigned m;
        int unsigned a;
        m = n + 1;
        a = m / P;
        if (phase == 3) begin
            bus.tx_left  = exp_left;
            bus.tx_right = exp_right;
        end else begin
            if (n % P == 0 && (n / P) % FRAME_SLOTS == 8) bus.tx_left = W'($urandom);
            if (n / P >= FRAME_SLOTS && $urandom_range(0, 15) == 0) bus.tx_right = W'($urandom);
        end
        if (m % P == 0 && a % WORD_SLOTS == 1)
            tx_words[(a - 1) / WORD_SLOTS] = (a % FRAME_SLOTS == 1) ? 32'(bus.tx_left) : 32'(bus.tx_right);
        loop_en = (phase == 3) && (a >= FRAME_SLOTS + 1);
        ext_sd  = ext_bit(a);
        rx_bits[a] = loop_en ? tx_bit(a) : ext_sd;
    endtask

    task automatic step();
        int unsigned a;
        int unsigned s;
        @(negedge ck);
        n++;
        a = n / P;
        s = a % FRAME_SLOTS;
        exp_valid = 1'b0;
        if (n % P == P / 2) begin
            if (s == int'(LEFT_LATCH_SLOT)) exp_left = captured(a);
            if (s == int'(RIGHT_LATCH_SLOT)) begin
                exp_right = captured(a);
                exp_valid = 1'b1;
            end
            if (phase == 1) begin
                if (a == 32)  check("ramp_left0",  32'(bus.left),  32'h8234);
                if (a == 64)  check("ramp_right0", 32'(bus.right), 32'h8235);
                if (a == 96)  check("ramp_left1",  32'(bus.left),  32'h8236);
                if (a == 128) check("ramp_right1", 32'(bus.right), 32'h8237);
            end
        end
        check("sck",      32'(bus.sck), 32'((n % P) >= P / 2));
        check("posn",     32'(bus.frame_posn), s);
        check("ws",       32'(bus.ws), 32'(s >= 32));
        check("sd_out",   32'(bus.sd_out), 32'(tx_bit(a)));
        check("rx_valid", 32'(bus.rx_valid), 32'(exp_valid));
        check("left",     32'(bus.left), 32'(exp_left));
        check("right",    32'(bus.right), 32'(exp_right));
        drive();
    endtask

    task automatic apply_reset(input int unsigned hold);
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (hold) begin
            @(negedge ck);
            check_zero("rst_hold");
        end
        n         = 0;
        exp_left  = '0;
        exp_right = '0;
        exp_valid = 1'b0;
        loop_en   = 1'b0;
        foreach (rx_bits[i])  rx_bits[i]  = 1'b0;
        foreach (tx_words[i]) tx_words[i] = '0;
        rst_n = 1'b1;
        drive();
    endtask

    initial begin
        phase = 1;
        bus.tx_left  = 16'hA5C3;
        bus.tx_right = 16'h0001;
        foreach (rx_words[i]) rx_words[i] = (i < 4) ? 32'h8234_0000 + 32'(i) * 32'h0001_0000 : $urandom;
        #1;
        apply_reset(5);
        repeat (P * (5 * FRAME_SLOTS + 40)) step();

        phase = 2;
        foreach (rx_words[i]) rx_words[i] = $urandom;
        bus.tx_left  = W'($urandom);
        bus.tx_right = W'($urandom);
        apply_reset(3);
        repeat (P * (4 * FRAME_SLOTS + 3)) step();

        phase = 3;
        foreach (rx_words[i]) rx_words[i] = {(i % 2 == 0) ? 16'h1234 : 16'hFEDC, 16'($urandom)};
        apply_reset(3);
        repeat (P * 5 * FRAME_SLOTS) step();
        check("loop_left",  32'(bus.left),  32'h1234);
        check("loop_right", 32'(bus.right), 32'hFEDC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_transceiver.md
Name: i2s_transceiver

Overview:
- Single-clock I2S master core: generates SCK, WS and a 6-bit frame position from the system clock.
- Deserialises a 64-slot stereo I2S input into 16-bit left/right words.
- Serialises 16-bit left/right words onto an I2S output.
- All logic runs on ck; SCK edges are internal ck-cycle enables, so loopback (sd_out to sd_in) works back-to-back.

Parameters:
- CK_DIV_LOG2, 2: SCK period = 2^CK_DIV_LOG2 ck cycles; minimum 1. At ck ≈ 12 MHz, SCK ≈ 3 MHz and frame rate ≈ 46.9 kHz.
- WIDTH, 16: audio sample width; 1..32.

Ports:
- ck in 1: system clock; all logic on its rising edge.
- rst_n in 1: asynchronous active-low reset.
- sck out 1: I2S bit clock.
- ws out 1: word select; 0 = left, 1 = right.
- frame_posn out 6: current bit slot, 0..63.
- sd_in in 1: serial data input.
- left out WIDTH: last received left sample.
- right out WIDTH: last received right sample.
- rx_valid out 1: one-ck pulse when right is updated (frame complete).
- tx_left in WIDTH: left sample to transmit.
- tx_right in WIDTH: right sample to transmit.
- sd_out out 1: serial data output.

Behaviour:
- Reset (async, rst_n=0): prescaler=0, sck=0, frame_posn=0, ws=0, rx shift register=0, left=0, right=0, rx_valid=0, tx shift register=0, sd_out=0. Outputs hold until rst_n deasserts. Mid-frame reset aborts the frame; the first full frame starts at slot 0.
- Clock generation:
  - CK_DIV_LOG2-bit prescaler increments every ck; sck = prescaler MSB (registered).
  - sck_rise enable: ck cycle where sck goes 0→1. sck_fall enable: ck cycle where sck goes 1→0.
  - frame_posn increments mod 64 on each sck_fall (63→0 wrap).
  - ws = frame_posn[5]: changes on the falling edge, one slot before the sample MSB (standard I2S).
- Slot map:
  - Left MSB in slot 1; left 32-bit word occupies slots 1..32.
  - Right MSB in slot 33; right word occupies slots 33..63 and slot 0.
  - Only the top WIDTH bits are significant.
- RX:
  - On sck_rise, shift sd_in into a 32-bit register, LSB in.
  - On sck_rise with frame_posn==32 (after the shift): left <= shreg[31:32-WIDTH].
  - On sck_rise with frame_posn==0 (after the shift): right <= shreg[31:32-WIDTH]; rx_valid=1 for that ck.
  - Outputs hold between updates.
- TX:
  - On sck_fall where frame_posn becomes 1: load {tx_left, zeros} into a 32-bit shift register and drive its MSB on sd_out.
  - On sck_fall where frame_posn becomes 33: same, using tx_right.
  - Other sck_fall edges: shift left by one, zero fill.
  - sd_out = register MSB, so it changes only on SCK falling edges. Slots 1..WIDTH carry left MSB-first; slots WIDTH+1..32 are 0; the right half is symmetric.
  - tx_left/tx_right are sampled only at the load edges. Changes mid-word do not affect the word in flight.
- Latency:
  - Sample whose MSB is at slot 1 of frame N appears on left at the slot-32 sck_rise of frame N.
  - With sd_out→sd_in loopback and tx_left=left, the looped-back left lags by exactly one frame.

Decomposition:
- Package i2s_pkg:
  - FRAME_SLOTS=64, WORD_SLOTS=32.
  - Slot constants LEFT_MSB_SLOT=1, RIGHT_MSB_SLOT=33, LEFT_LATCH_SLOT=32, RIGHT_LATCH_SLOT=0.
  - Typedef for the 6-bit slot index.
- Sub-module i2s_clock_gen: prescaler, sck, sck_rise/sck_fall enables, frame_posn, ws.
- RX and TX stay inline in the top.

Test Plan:
- Reset: hold rst_n=0 for 5 ck, release → sck=0, ws=0, frame_posn=0, left=right=0, sd_out=0. Then sck period=4 ck, frame_posn 0..63 wraps, ws=1 exactly for slots 32..63.
- RX ramp:
  - Drive a 32-bit word MSB-first starting slot 1, changing on SCK falling edges; first word 0x82340000, each subsequent word (alternating left/right) +0x00010000.
  - Required: left=0x8234 after slot 32, right=0x8235 after slot 0 with one rx_valid pulse; next frame left=0x8236, right=0x8237.
- TX pattern: tx_left=0xA5C3, tx_right=0x0001.
  - Required: sd_out slots 1..16 = 1010010111000011, slots 17..32 = 0.
  - Slots 33..48 = 0x0001 MSB-first, slots 49..63 and 0 = 0.
- Loopback: sd_out→sd_in with tx_left=left and tx_right=right, RX driven from a second stimulus of 0x1234/0xFEDC → the loopback receiver reports 0x1234/0xFEDC one frame after left/right update.
- Mid-word change: change tx_left at slot 8 → the current word finishes unchanged; the new value appears from the next slot 1.
- Reset mid-frame: assert rst_n at slot 40 → all outputs zero immediately (async). After release, the first full frame starts at slot 0 and decodes correctly.
